mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL provide start, input, 1: request a new operation, sampled on a rising edge.
REQ-004 SHALL provide op, input, 2: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL provide SrcA, input, 32: first operand (multiplicand or dividend), fed from ReadData1.
REQ-006 SHALL provide SrcB, input, 32: second operand (multiplier or divisor), fed from ReadData2.
REQ-007 SHALL provide MoveReq, input, 1: request an mfhi/mflo write-back.
REQ-008 SHALL provide MoveSel, input, 1: 0 selects LO, 1 selects HI.
REQ-009 SHALL provide MoveReg, input, 5: destination register for the move.
REQ-010 SHALL provide busy, output, 1: high whenever state is not IDLE.
REQ-011 SHALL provide done, output, 1: one-cycle completion pulse.
REQ-012 SHALL provide div_by_zero, output, 1: qualifies done for a DIV or DIVU with SrcB = 0.
REQ-013 SHALL provide HI and LO, outputs, 32 each: architectural result registers.
REQ-014 SHALL provide stall, output, 1 (combinational): MoveReq is high while state is PREP, RUN or FIX.
REQ-015 SHALL provide RegWrite (1), WriteReg (5) and WriteData (32) as outputs driving the register file write port.

Function
REQ-016 SHALL implement states IDLE, PREP, RUN, FIX and DONE.
REQ-017 SHALL, in IDLE with start = 1, latch op, SrcA and SrcB and move to PREP; start SHALL be ignored in every other state.
REQ-018 PREP SHALL form operand magnitudes: absolute values for MULT/DIV, unchanged for MULTU/DIVU.
REQ-019 PREP SHALL record the result signs, then move to RUN with a 5-bit iteration counter = 0.
REQ-020 PREP SHALL go directly to DONE if the operation is a divide and the divisor = 0.
REQ-021 RUN SHALL perform exactly 32 iterations, one per cycle: shift-add for multiply, restoring shift-subtract for divide; it SHALL then move to FIX.
REQ-022 FIX SHALL apply sign correction and load HI/LO, then move to DONE.
REQ-023 For a multiply, {HI,LO} SHALL hold the 64-bit product, negated when the operand signs differ (MULT only).
REQ-024 For a divide, LO SHALL hold the quotient and HI the remainder.
REQ-025 For DIV, the quotient SHALL be negative when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0 (truncation, no trap).
REQ-027 Latency SHALL be fixed: with start sampled at edge E, done SHALL be high in the cycle after edge E+34.
REQ-028 For divide-by-zero, done SHALL instead be high in the cycle after edge E+1.
REQ-029 In DONE, done SHALL = 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-030 On divide-by-zero, div_by_zero SHALL = 1 during that done cycle and HI/LO SHALL remain unchanged; otherwise div_by_zero SHALL = 0.
REQ-031 A MoveReq sampled in IDLE or DONE SHALL produce, in the next cycle only, RegWrite = 1, WriteReg = MoveReg and WriteData = the selected HI/LO value current at the sampling edge.
REQ-032 A MoveReq sampled in PREP, RUN or FIX SHALL produce no write; stall SHALL be high and the requester SHALL hold MoveReq.
REQ-033 When MoveReg = 0, RegWrite SHALL stay 0 (register $0 is never written).
REQ-034 start and MoveReq sampled together in IDLE SHALL both be accepted; the move SHALL use the old HI/LO.
REQ-035 RegWrite SHALL be 0 in every cycle not covered by REQ-031.

Reset
REQ-036 rst_n low SHALL immediately force state to IDLE and set HI, LO, busy, done, div_by_zero, RegWrite, WriteReg and WriteData to 0, in any state.
REQ-037 Reset mid-operation SHALL abandon the operation with no done pulse; a start after reset release SHALL run normally.

Verification
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001, done exactly in the cycle after edge E+34, busy high from E+1 through the done cycle.
REQ-039 MULT 0xFFFFFFFD (-3) x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-040 DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 7/2 -> LO = 3, HI = 1.
REQ-041 DIVU 5 / 0 with HI = LO = 0x11111111 beforehand -> done and div_by_zero high in the cycle after E+1; HI/LO unchanged.
REQ-042 MoveReq (MoveSel = 1, MoveReg = 3) held from RUN cycle 5 -> stall high and RegWrite low until DONE; then one cycle of RegWrite = 1, WriteReg = 3, WriteData = new HI. The same move with MoveReg = 0 -> no RegWrite.
REQ-043 rst_n pulsed low at RUN iteration 10 -> busy, done, HI and LO are 0 immediately with no done pulse; a following MULTU 6 x 7 -> LO = 42, HI = 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO result registers and an
// mfhi/mflo write-back port. One bit per cycle, fixed latency.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        MoveReq,
  input  logic        MoveSel,
  input  logic [4:0]  MoveReg,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [31:0] r_ah, r_al;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r;
  logic [31:0] r_hi, r_lo;
  logic        r_done, r_dbz;
  logic        r_regwrite;
  logic [4:0]  r_wreg;
  logic [31:0] r_wdata;

  logic        w_signed, w_is_div;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_sh;
  logic        w_div_ge;
  logic [31:0] w_div_rem;
  logic [31:0] w_ah_nx, w_al_nx;
  logic [63:0] w_prod, w_prod_neg;

  assign w_signed  = r_op[0];
  assign w_is_div  = r_op[1];
  assign w_mag_a   = (w_signed && r_a[31]) ? -r_a : r_a;
  assign w_mag_b   = (w_signed && r_b[31]) ? -r_b : r_b;

  // Multiply: r_ah accumulates, r_al holds the shifting multiplier.
  // Divide: r_ah is the partial remainder, r_al shifts dividend out and quotient in.
  assign w_mul_sum = {1'b0, r_ah} + (r_al[0] ? {1'b0, r_b} : 33'd0);
  assign w_div_sh  = {r_ah, r_al[31]};
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
  assign w_div_rem = w_div_sh[31:0] - r_b;
  assign w_prod    = {r_ah, r_al};
  assign w_prod_neg = -w_prod;

  always_comb begin
    w_ah_nx = w_mul_sum[32:1];
    w_al_nx = {w_mul_sum[0], r_al[31:1]};
    if (w_is_div) begin
      w_ah_nx = w_div_ge ? w_div_rem : w_div_sh[31:0];
      w_al_nx = {r_al[30:0], w_div_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_a        <= '0;
      r_b        <= '0;
      r_ah       <= '0;
      r_al       <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_regwrite <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_regwrite <= 1'b0;
      // Moves only see HI/LO while no operation is in flight; $0 is never written.
      if (MoveReq && (r_state == S_IDLE || r_state == S_DONE)) begin
        r_regwrite <= (MoveReg != 5'd0);
        r_wreg     <= MoveReg;
        r_wdata    <= MoveSel ? r_hi : r_lo;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= SrcA;
            r_b     <= SrcB;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_ah    <= '0;
          r_al    <= w_mag_a;
          r_b     <= w_mag_b;
          r_cnt   <= '0;
          r_neg_q <= w_signed & (r_a[31] ^ r_b[31]);
          r_neg_r <= w_signed & r_a[31];
          if (w_is_div && r_b == 32'd0) begin
            r_done  <= 1'b1;
            r_dbz   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_ah  <= w_ah_nx;
          r_al  <= w_al_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          if (w_is_div) begin
            r_lo <= r_neg_q ? -r_al : r_al;
            r_hi <= r_neg_r ? -r_ah : r_ah;
          end else begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign stall       = MoveReq && (r_state == S_PREP || r_state == S_RUN || r_state == S_FIX);
  assign RegWrite    = r_regwrite;
  assign WriteReg    = r_wreg;
  assign WriteData   = r_wdata;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table through a result scoreboard, then
// hand sequences for move/stall interaction, ignored start and mid-op reset.
module tb_mult_div_unit;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [31:0] SrcA, SrcB;
  logic        MoveReq, MoveSel;
  logic [4:0]  MoveReg;
  logic        busy, done, div_by_zero, stall, RegWrite;
  logic [31:0] HI, LO, WriteData;
  logic [4:0]  WriteReg;

  mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .MoveReq(MoveReq), .MoveSel(MoveSel), .MoveReg(MoveReg),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO),
    .stall(stall), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives start for one cycle; returns at the negedge of the cycle after edge E.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; SrcA = a; SrcB = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    bit   got, busy_ok;
    e.hi = v.hi; e.lo = v.lo; e.dbz = v.dbz; e.lat = v.dbz ? 2 : 35;
    sb.push_back(e);
    start_op(v.op, v.a, v.b);
    got = 0; busy_ok = 1;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (!busy) busy_ok = 0;
      if (done) begin
        got = 1;
        e = sb.pop_front();
        chk("latency", 64'(k), 64'(e.lat));
        chk("HI", {32'd0, HI}, {32'd0, e.hi});
        chk("LO", {32'd0, LO}, {32'd0, e.lo});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
      end
    end
    if (!got) begin
      chk("done_timeout", 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    chk("busy_during_op", {63'd0, busy_ok}, 64'd1);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  // Move held from RUN cycle 5 on a MULTU 0xFFFFFFFF^2; new HI = 0xFFFFFFFE.
  task automatic move_during_run(input logic [4:0] dst);
    bit st_ok, rw_ok;
    start_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    st_ok = 1; rw_ok = 1;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      if (k >= 7) begin
        if (!stall) st_ok = 0;
        if (RegWrite) rw_ok = 0;
      end
      if (k == 6) begin MoveReq = 1'b1; MoveSel = 1'b1; MoveReg = dst; end
    end
    chk("stall_held", {63'd0, st_ok}, 64'd1);
    chk("no_write_while_busy", {63'd0, rw_ok}, 64'd1);
    @(negedge clk);
    chk("move_done", {63'd0, done}, 64'd1);
    chk("move_stall_in_done", {63'd0, stall}, 64'd0);
    chk("move_rw_in_done", {63'd0, RegWrite}, 64'd0);
    @(negedge clk);
    MoveReq = 1'b0;
    chk("move_regwrite", {63'd0, RegWrite}, (dst != 0) ? 64'd1 : 64'd0);
    if (dst != 0) begin
      chk("move_writereg", {59'd0, WriteReg}, {59'd0, dst});
      chk("move_writedata", {32'd0, WriteData}, 64'h0FFFFFFFE);
    end
    @(negedge clk);
    chk("move_rw_single", {63'd0, RegWrite}, 64'd0);
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[4]  = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 1'b1};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[9]  = '{DIV,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000003, 1'b1};
    vecs[10] = '{MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vecs[12] = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[13] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; SrcA = '0; SrcB = '0;
    MoveReq = 1'b0; MoveSel = 1'b0; MoveReg = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_HI_LO", {HI, LO}, 64'd0);
    chk("rst_write_port", {RegWrite, WriteReg, WriteData}, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) issue(vecs[i]);

    // Move from IDLE: HI = 1 after the last vector.
    MoveReq = 1'b1; MoveSel = 1'b1; MoveReg = 5'd7;
    @(negedge clk);
    MoveReq = 1'b0;
    chk("idle_move_rw", {63'd0, RegWrite}, 64'd1);
    chk("idle_move_data", {27'd0, WriteReg, WriteData}, {27'd0, 5'd7, 32'd1});
    @(negedge clk);
    chk("idle_move_single", {63'd0, RegWrite}, 64'd0);

    move_during_run(5'd3);
    move_during_run(5'd0);

    // Start and move together in IDLE; a start during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; op = MULTU; SrcA = 32'd6; SrcB = 32'd7;
    MoveReq = 1'b1; MoveSel = 1'b0; MoveReg = 5'd9;
    @(negedge clk);
    start = 1'b0; MoveReq = 1'b0;
    chk("joint_move_rw", {63'd0, RegWrite}, 64'd1);
    chk("joint_move_data", {27'd0, WriteReg, WriteData}, {27'd0, 5'd9, 32'd1});
    for (int k = 2; k <= 35; k++) begin
      @(negedge clk);
      start = (k == 10);
      if (k == 10) begin op = DIVU; SrcA = 32'd100; SrcB = 32'd0; end
    end
    chk("joint_done", {62'd0, done, div_by_zero}, 64'd2);
    chk("joint_result", {HI, LO}, 64'd42);
    begin
      bit extra = 0;
      for (int k = 36; k <= 40; k++) begin
        @(negedge clk);
        if (done || busy) extra = 1;
      end
      chk("ignored_start_no_op", {63'd0, extra}, 64'd0);
    end

    // Reset during RUN iteration 10.
    start_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("midrst_HI_LO", {HI, LO}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit spurious = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done || busy) spurious = 1;
      end
      chk("midrst_no_done", {63'd0, spurious}, 64'd0);
    end
    issue('{MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0});

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
